// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared encodings and constants for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;
  localparam int BURST_W = 4;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: combinational two-way round-robin picker producing a one-hot grant.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);
  // A sole requester (or none) passes straight through; a tie goes to the port that did not win last.
  always_comb pick = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between core and loader
// with round-robin priority, bounded locked bursts and one-cycle read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_nx;
  logic last;
  logic [BURST_W-1:0] burst_cnt, cnt_nx;
  logic [1:0] pick, win;
  logic hold0, hold1, sat, wsel_we, wsel_lock;

  arb_rr2 u_rr (.req({req1, req0}), .last(last), .pick(pick));

  always_comb begin
    hold0 = state == OWN0 && req0 && lock0;
    hold1 = state == OWN1 && req1 && lock1;
    sat = burst_cnt == BURST_W'(MAX_BURST);
    // An owner keeps the port until its burst budget runs out while the other side waits.
    win = !rst_n ? 2'b00 :
          hold0 ? ((sat && req1) ? 2'b10 : 2'b01) :
          hold1 ? ((sat && req0) ? 2'b01 : 2'b10) : pick;
    wsel_we = win[1] ? we1 : we0;
    wsel_lock = win[1] ? lock1 : lock0;
    gnt0 = win[0];
    gnt1 = win[1];
    mem_addr = win[0] ? addr0 : win[1] ? addr1 : '0;
    mem_wdata = win[0] ? wdata0 : win[1] ? wdata1 : '0;
    mem_we = |win & wsel_we;
    mem_re = |win & ~wsel_we;
    state_nx = (|win && wsel_lock) ? (win[1] ? OWN1 : OWN0) : IDLE;
    cnt_nx = state_nx == IDLE ? '0 :
             state_nx != state ? BURST_W'(1) :
             sat ? burst_cnt : burst_cnt + 1'b1;
    rdata0 = rvalid0 ? mem_rdata : '0;
    rdata1 = rvalid1 ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last <= PORT_LOAD;
      burst_cnt <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state <= state_nx;
      burst_cnt <= cnt_nx;
      if (|win) last <= win[1] ? PORT_LOAD : PORT_CORE;
      rvalid0 <= win[0] & ~we0;
      rvalid1 <= win[1] & ~we1;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a behavioural arbiter/memory model checked every cycle.
module tb_dmem_arbiter;
  localparam int MAXB = 4;
  logic clk = 0, rst_n = 0;
  logic req0, req1, we0, we1, lock0, lock1;
  logic [4:0] addr0, addr1, mem_addr;
  logic [7:0] wdata0, wdata1, mem_wdata, mem_rdata = 0, rdata0, rdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_re;
  logic [7:0] mem[32] = '{default: 8'h00};
  logic [7:0] mm[32] = '{default: 8'h00};
  int checks = 0, errors = 0;
  int ew = -1, own = -1, run = 0, last_m = 1;
  logic [1:0] erv = 0;
  logic [7:0] erd = 0;
  logic [5:0] pat;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_win();
    logic [1:0] r, l;
    r = {req1, req0};
    l = {lock1, lock0};
    if (own >= 0 && r[own] && l[own]) return (run == MAXB && r[1-own]) ? 1 - own : own;
    if (r == 2'b11) return 1 - last_m;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    w = rst_n ? model_win() : -1;
    ew <= w;
    chk("gnt", {gnt1, gnt0}, w < 0 ? 2'b00 : w == 1 ? 2'b10 : 2'b01);
    chk("mem_we", mem_we, w == 0 ? we0 : w == 1 ? we1 : 1'b0);
    chk("mem_re", mem_re, w == 0 ? !we0 : w == 1 ? !we1 : 1'b0);
    chk("mem_addr", mem_addr, w == 0 ? addr0 : w == 1 ? addr1 : 5'd0);
    chk("mem_wdata", mem_wdata, w == 0 ? wdata0 : w == 1 ? wdata1 : 8'd0);
    chk("rvalid", {rvalid1, rvalid0}, rst_n ? erv : 2'b00);
    chk("rdata0", rdata0, (rst_n && erv[0]) ? erd : 8'd0);
    chk("rdata1", rdata1, (rst_n && erv[1]) ? erd : 8'd0);
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      own <= -1;
      run <= 0;
      last_m <= 1;
      erv <= 0;
    end else begin
      erv <= {ew == 1 && !we1, ew == 0 && !we0};
      erd <= mm[ew == 1 ? addr1 : addr0];
      if (ew < 0) begin
        own <= -1;
        run <= 0;
      end else begin
        last_m <= ew;
        if (ew == 1 ? lock1 : lock0) begin
          own <= ew;
          run <= (own == ew) ? (run < MAXB ? run + 1 : MAXB) : 1;
        end else begin
          own <= -1;
          run <= 0;
        end
        if (ew == 1 ? we1 : we0) mm[ew == 1 ? addr1 : addr0] <= ew == 1 ? wdata1 : wdata0;
      end
    end

  task automatic set0(input logic r, input logic w, input logic l, input logic [4:0] a, input logic [7:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l, input logic [4:0] a, input logic [7:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set0(1, 0, 0, 0, 0);
    set1(1, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    chk("reset_gnt_lit", {gnt1, gnt0, mem_re}, 3'b000);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("first_tie_gnt0", {gnt1, gnt0}, 2'b01);
    tick();
    set1(0, 0, 0, 0, 0);
    set0(1, 1, 0, 5, 8'hA5);
    @(negedge clk);
    chk("wr_lit", {gnt0, mem_we, mem_addr}, {1'b1, 1'b1, 5'd5});
    tick();
    set0(1, 0, 0, 5, 0);
    @(negedge clk);
    chk("rd_lit", {gnt0, mem_re}, 2'b11);
    tick();
    set0(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rdata0_lit", {rvalid0, rdata0, rdata1}, {1'b1, 8'hA5, 8'h00});
    tick();
    set0(1, 0, 0, 3, 0);
    set1(1, 0, 0, 4, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_gnt1_lit", gnt1, (i % 2) == 0);
      tick();
    end
    set1(1, 0, 1, 9, 0);
    pat = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("burst_gnt1_lit", gnt1, pat[i]);
      tick();
    end
    set1(0, 0, 0, 0, 0);
    set0(1, 0, 1, 2, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lock0_gnt0_lit", gnt0, 1'b1);
      tick();
    end
    @(negedge clk);
    chk("burst_sat_lit", dut.burst_cnt, 4);
    tick();
    set0(0, 0, 0, 0, 0);
    set1(1, 0, 0, 7, 0);
    @(negedge clk);
    chk("pre_rst_gnt1_lit", gnt1, 1'b1);
    #2 rst_n = 0;
    @(posedge clk);
    #1;
    chk("rst_rvalid1_lit", rvalid1, 1'b0);
    set0(1, 0, 0, 1, 0);
    #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_gnt0_lit", {gnt1, gnt0, rvalid1}, 3'b010);
    tick();
    @(negedge clk);
    chk("post_rst_rvalid1_lit", rvalid1, 1'b0);
    tick();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 32x8 data memory between two requesters: port 0 is the core (ACC store / ALU operand fetch) and port 1 is the loader/debug engine. Each cycle it picks at most one access using round-robin priority, with optional locked bursts bounded by MAX_BURST. It also returns read data with the memory's one-cycle synchronous read latency. It sits directly in front of the data memory and drives its addr, write_enable, read_enable and write_data inputs.

Parameters:
ADDR_W, 5, memory address width (32 entries)
DATA_W, 8, data width
MAX_BURST, 4, maximum consecutive locked grants to one port while the other port is requesting; legal range 1..15

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
req0 / req1  in  1  access request; must be held with its attributes stable until the matching gnt
we0 / we1  in  1  1 = write, 0 = read
lock0 / lock1  in  1  request ownership across consecutive accesses
addr0 / addr1  in  ADDR_W  access address
wdata0 / wdata1  in  DATA_W  write data
gnt0 / gnt1  out  1  combinational; the access is issued at the next posedge
rvalid0 / rvalid1  out  1  registered; read data is valid this cycle
rdata0 / rdata1  out  DATA_W  mem_rdata when the matching rvalid is high, else 0
mem_addr  out  ADDR_W  to memory addr
mem_we  out  1  to memory write_enable
mem_re  out  1  to memory read_enable
mem_wdata  out  DATA_W  to memory write_data
mem_rdata  in  DATA_W  from memory read_data; registered in memory, valid the cycle after mem_re

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_gnt=1 so port 0 wins the first tie, burst_cnt=0.
  - rvalid0/1=0; all mem_* outputs=0; gnt0/1=0.
  - A read granted in the cycle before reset never produces rvalid.
- States: IDLE (no owner), OWN0, OWN1.
- Winner selection, evaluated combinationally each cycle:
  - OWNx with reqx=1 and lockx=1: x wins, unless burst_cnt==MAX_BURST and the other port is requesting; then the other port wins.
  - Otherwise, including OWNx with reqx=0 or lockx=0: round-robin. A sole requester wins. If both request, the port != last_gnt wins.
  - At most one gnt per cycle.
  - No request: gnt0=gnt1=0 and mem_we=mem_re=mem_addr=mem_wdata=0.
- Issue:
  - mem_addr, mem_wdata and mem_we/mem_re (from the winner's we) are muxed combinationally from the winner, alongside gnt.
  - The memory samples them at the posedge, so a write completes at that edge.
  - A read's data is on mem_rdata in the following cycle.
- Read return:
  - rvalid_w is registered at the grant edge and is high exactly one cycle.
  - rdata_w = mem_rdata in that cycle only; rdata is 0 otherwise.
  - Back-to-back reads give rvalid on consecutive cycles.
  - Write-then-read of the same address on consecutive cycles returns the new data.
- Transitions, at the posedge on a grant to port w:
  - last_gnt <= w.
  - If lockw=1: next state is OWNw. burst_cnt <= 1 if ownership is new, else burst_cnt+1, saturating at MAX_BURST.
  - If lockw=0: next state is IDLE, burst_cnt <= 0.
  - If there is no grant: next state is IDLE, burst_cnt <= 0.
- Preemption at MAX_BURST: the other port is granted and becomes owner if its own lock=1. The preempted owner then competes by round-robin.
- Lock with the other port idle: the burst continues unbounded and burst_cnt saturates.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2)
  - PORT_CORE=0, PORT_LOAD=1
  - burst counter width constant BURST_W=4
- One sub-module: arb_rr2. It is a combinational 2-way round-robin picker: inputs req[1:0] and last; outputs a one-hot pick. The lock/burst FSM, muxing and rvalid registers stay in dmem_arbiter.

Test Plan:
- Reset: hold rst_n=0 with req0=req1=1 -> gnt, rvalid and all mem_* outputs are 0; after release, the first tie grants port 0.
- Port 0 writes 0xA5 to addr 5, then reads addr 5 on the next cycle -> gnt0 in both cycles; mem_we=1 with mem_addr=5 then mem_re=1; rvalid0=1 and rdata0=0xA5 one cycle after the read grant; rdata1=0.
- req0=req1=1 continuously with reads, no lock -> grants alternate 0,1,0,1; rvalid follows each grant by one cycle on the matching port.
- MAX_BURST=4: lock1=req1=1 held, req0=1 throughout -> port 1 gets 4 consecutive grants, then gnt0 for one cycle, then port 1 resumes as owner.
- lock0=req0=1 for 8 cycles, req1=0 -> 8 consecutive gnt0; burst_cnt saturates at 4; no preemption.
- Port 1 read granted at addr 7, then rst_n pulsed low in the next cycle -> rvalid1 never asserts; after release with both requesting, port 0 is granted first.
